operand_prep_stage: RTL and testbench

Parametrised register-file and operand-preparation pipeline stage for the ARM-LP datapath, sitting between decode and the ALU. It holds the architectural register file, accepts write-back from the memory/write-back stage, and produces two ALU operands plus a sign-extended branch offset. Unlike the earlier fixed 6-phase design, it uses a valid/ready handshake, same-cycle write-back bypass, and stall-time operand refresh.

---
 rtl/operand_prep_stage.sv | 134 +++++++++++++
 tb/tb_operand_prep_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_prep_stage.sv
// operand_prep_stage
// Register file plus operand-preparation stage between decode and the ALU.
// Holds the architectural registers, takes write-back from the later stage,
// and presents two ALU operands and a sign-extended branch offset through a
// single valid/ready output register.
// Optional feature: define ZERO_REG_EN to make register NREGS-1 a hardwired
// zero register (writes to it are dropped, so it always reads as zero).

module operand_prep_stage #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [ADDR_W-1:0] reg1,
   input  logic [ADDR_W-1:0] reg2,
   input  logic              alu_src,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic [DATA_W-1:0] pc_offset
);

   localparam logic STATE_EMPTY = 1'b0;
   localparam logic STATE_FULL  = 1'b1;

   logic              state;
   logic [DATA_W-1:0] regFile [NREGS];

   logic [ADDR_W-1:0] heldReg1;
   logic [ADDR_W-1:0] heldReg2;
   logic              heldAluSrc;
   logic [DATA_W-1:0] op1Reg;
   logic [DATA_W-1:0] op2Reg;
   logic [DATA_W-1:0] pcOffsetReg;

   logic              acceptIn;
   logic              transferOut;
   logic              wbWrite;
   logic [DATA_W-1:0] bypass1;
   logic [DATA_W-1:0] bypass2;
   logic [DATA_W-1:0] immValue;
   logic [DATA_W-1:0] branchOffset;
   logic              unusedInstrMsb;

   // The zero register is never written, so after reset it reads as zero
   // through the array, the bypass path and the stall refresh alike.
`ifdef ZERO_REG_EN
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NREGS - 1);
   assign wbWrite = wb_en && (wb_addr != ZERO_ADDR);
`else
   assign wbWrite = wb_en;
`endif

   assign acceptIn    = in_valid && in_ready;
   assign transferOut = (state == STATE_FULL) && out_ready;
   assign in_ready    = (state == STATE_EMPTY) || out_ready;
   assign out_valid   = (state == STATE_FULL);

   assign read_data1 = op1Reg;
   assign read_data2 = op2Reg;
   assign pc_offset  = pcOffsetReg;

   // Bit 31 of the instruction does not feed any immediate or offset field.
   assign unusedInstrMsb = instr[31];

   // Same-cycle write-back wins over the stale array value on capture.
   assign bypass1 = (wbWrite && (wb_addr == reg1)) ? wb_data : regFile[reg1];
   assign bypass2 = (wbWrite && (wb_addr == reg2)) ? wb_data : regFile[reg2];

   // D-type loads/stores carry a 9-bit offset, arithmetic immediates 12 bits.
   assign immValue = (mem_read || mem_write)
                   ? {{(DATA_W-9){instr[20]}},  instr[20:12]}
                   : {{(DATA_W-12){instr[21]}}, instr[21:10]};

   // B/BL opcode selects the 26-bit offset; everything else uses the CB field.
   assign branchOffset = (instr[30:26] == 5'b00101)
                       ? {{(DATA_W-26){instr[25]}}, instr[25:0]}
                       : {{(DATA_W-19){instr[23]}}, instr[23:5]};

   // Architectural register file: cleared on reset, written by write-back
   // independently of the operand handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regFile[i] <= '0;
         end
      end else if (wbWrite) begin
         regFile[wb_addr] <= wb_data;
      end
   end

   // Output stage: load on accept, drain on transfer-out, and while stalled
   // keep held register operands in step with any write-back that hits them.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= STATE_EMPTY;
         op1Reg      <= '0;
         op2Reg      <= '0;
         pcOffsetReg <= '0;
         heldReg1    <= '0;
         heldReg2    <= '0;
         heldAluSrc  <= 1'b0;
      end else if (acceptIn) begin
         state       <= STATE_FULL;
         op1Reg      <= bypass1;
         op2Reg      <= alu_src ? immValue : bypass2;
         pcOffsetReg <= branchOffset;
         heldReg1    <= reg1;
         heldReg2    <= reg2;
         heldAluSrc  <= alu_src;
      end else if (transferOut) begin
         state <= STATE_EMPTY;
      end else if (state == STATE_FULL) begin
         if (wbWrite && (wb_addr == heldReg1)) begin
            op1Reg <= wb_data;
         end
         if (wbWrite && (wb_addr == heldReg2) && !heldAluSrc) begin
            op2Reg <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_operand_prep_stage.sv
// tb_operand_prep_stage
// Directed scenarios followed by a randomized run, all compared against a
// behavioural model of the stage. Honours ZERO_REG_EN if defined.

module tb_operand_prep_stage;

   localparam int DATA_W = 32;
   localparam int NREGS  = 32;
   localparam int ADDR_W = 5;

`ifdef ZERO_REG_EN
   localparam logic [31:0] X31_EXPECT = 32'h0;
`else
   localparam logic [31:0] X31_EXPECT = 32'h55;
`endif

   logic              clock;
   logic              reset;
   logic              inValid;
   logic              inReady;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] reg1;
   logic [ADDR_W-1:0] reg2;
   logic              aluSrc;
   logic              memRead;
   logic              memWrite;
   logic              wbEn;
   logic [ADDR_W-1:0] wbAddr;
   logic [DATA_W-1:0] wbData;
   logic              outValid;
   logic              outReady;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic [DATA_W-1:0] pcOffset;

   int checkCount = 0;
   int failCount  = 0;

   // Behavioural model state
   logic [31:0]       mRegs [NREGS];
   logic              mFull;
   logic [31:0]       mOp1;
   logic [31:0]       mOp2;
   logic [31:0]       mPc;
   logic [ADDR_W-1:0] mSrc1;
   logic [ADDR_W-1:0] mSrc2;
   logic              mImm;

   operand_prep_stage #(
      .DATA_W(DATA_W),
      .NREGS (NREGS),
      .ADDR_W(ADDR_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .instr     (instr),
      .reg1      (reg1),
      .reg2      (reg2),
      .alu_src   (aluSrc),
      .mem_read  (memRead),
      .mem_write (memWrite),
      .wb_en     (wbEn),
      .wb_addr   (wbAddr),
      .wb_data   (wbData),
      .out_valid (outValid),
      .out_ready (outReady),
      .read_data1(readData1),
      .read_data2(readData2),
      .pc_offset (pcOffset)
   );

   // Free-running 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count one comparison and report it if it disagrees
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Two's-complement value of an unsigned field of the given width
   function automatic logic [31:0] signedField(input longint field, input int bits);
      longint v;
      v = field;
      if (field >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
      return 32'(v);
   endfunction

   function automatic logic [31:0] modelImm(input logic [31:0] ins, input logic isMem);
      if (isMem) return signedField(longint'(ins[20:12]), 9);
      return signedField(longint'(ins[21:10]), 12);
   endfunction

   function automatic logic [31:0] modelBranch(input logic [31:0] ins);
      if (ins[30:26] == 5'b00101) return signedField(longint'(ins[25:0]), 26);
      return signedField(longint'(ins[23:5]), 19);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NREGS; i++) mRegs[i] = 32'h0;
      mFull = 1'b0;
      mOp1  = 32'h0;
      mOp2  = 32'h0;
      mPc   = 32'h0;
      mSrc1 = '0;
      mSrc2 = '0;
      mImm  = 1'b0;
   endtask

   // Advance the model by one clock: apply the write-back to a fresh copy of
   // the register file first, then every operand read sees the post-write
   // file. A stalled entry always mirrors its source registers.
   task automatic modelStep();
      logic [31:0] nextRegs [NREGS];
      logic        accept;
      nextRegs = mRegs;
      if (wbEn) begin
`ifdef ZERO_REG_EN
         if (int'(wbAddr) != NREGS - 1) nextRegs[wbAddr] = wbData;
`else
         nextRegs[wbAddr] = wbData;
`endif
      end
      accept = inValid && (!mFull || outReady);
      if (accept) begin
         mFull = 1'b1;
         mSrc1 = reg1;
         mSrc2 = reg2;
         mImm  = aluSrc;
         mOp1  = nextRegs[reg1];
         mOp2  = aluSrc ? modelImm(instr, memRead || memWrite) : nextRegs[reg2];
         mPc   = modelBranch(instr);
      end else if (mFull && outReady) begin
         mFull = 1'b0;
      end else if (mFull) begin
         mOp1 = nextRegs[mSrc1];
         if (!mImm) mOp2 = nextRegs[mSrc2];
      end
      mRegs = nextRegs;
   endtask

   task automatic setIdle();
      inValid  = 1'b0;
      instr    = 32'h0;
      reg1     = '0;
      reg2     = '0;
      aluSrc   = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      wbEn     = 1'b0;
      wbAddr   = '0;
      wbData   = '0;
      outReady = 1'b1;
   endtask

   // One cycle: compare all outputs to the model, then clock both forward.
   // Called just after a rising edge with this cycle's inputs already set.
   task automatic applyStimulus();
      #1;
      checkOutput("in_ready",   32'(inReady),  32'(!mFull || outReady));
      checkOutput("out_valid",  32'(outValid), 32'(mFull));
      checkOutput("read_data1", readData1, mOp1);
      checkOutput("read_data2", readData2, mOp2);
      checkOutput("pc_offset",  pcOffset,  mPc);
      modelStep();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [ADDR_W-1:0] pickReg();
      int r;
      r = $urandom_range(0, 9);
      return (r < 8) ? ADDR_W'(r) : ADDR_W'(NREGS - 1);
   endfunction

   // Main sequence: directed scenarios, then randomized traffic
   initial begin
      reset = 1'b1;
      setIdle();
      modelReset();
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_out_valid", 32'(outValid), 32'h0);
      checkOutput("reset_in_ready",  32'(inReady),  32'h1);
      checkOutput("reset_rd1",       readData1, 32'h0);
      checkOutput("reset_rd2",       readData2, 32'h0);
      checkOutput("reset_pc",        pcOffset,  32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Write X3 then read it on both ports
      wbEn = 1'b1; wbAddr = 5'd3; wbData = 32'h0000_00AA;
      applyStimulus();
      setIdle();
      inValid = 1'b1; reg1 = 5'd3; reg2 = 5'd3; outReady = 1'b0;
      applyStimulus();
      setIdle();
      checkOutput("x3_valid", 32'(outValid), 32'h1);
      checkOutput("x3_rd1",   readData1, 32'h0000_00AA);
      checkOutput("x3_rd2",   readData2, 32'h0000_00AA);
      applyStimulus();

      // Same-cycle bypass
      inValid = 1'b1; reg1 = 5'd5; wbEn = 1'b1; wbAddr = 5'd5; wbData = 32'h1234;
      applyStimulus();
      setIdle();
      checkOutput("bypass_rd1", readData1, 32'h1234);
      applyStimulus();

      // Stall refresh of a register operand
      inValid = 1'b1; reg2 = 5'd7; outReady = 1'b0;
      applyStimulus();
      setIdle();
      outReady = 1'b0; wbEn = 1'b1; wbAddr = 5'd7; wbData = 32'hBEEF;
      applyStimulus();
      setIdle();
      checkOutput("refresh_rd2", readData2, 32'hBEEF);
      applyStimulus();

      // Stall with an immediate operand 2: no refresh (ADDI imm 0x07F)
      inValid = 1'b1; reg2 = 5'd7; aluSrc = 1'b1; instr = 32'h0001_FC00; outReady = 1'b0;
      applyStimulus();
      setIdle();
      outReady = 1'b0; wbEn = 1'b1; wbAddr = 5'd7; wbData = 32'h1111;
      applyStimulus();
      setIdle();
      checkOutput("addi_imm_held", readData2, 32'h0000_007F);
      applyStimulus();

      // LDUR negative offset
      inValid = 1'b1; aluSrc = 1'b1; memRead = 1'b1; instr = 32'h001F_F000;
      applyStimulus();
      setIdle();
      checkOutput("ldur_imm", readData2, 32'hFFFF_FFFF);

      // B with offset -2
      inValid = 1'b1; instr = 32'h17FF_FFFE;
      applyStimulus();
      setIdle();
      checkOutput("b_offset", pcOffset, 32'hFFFF_FFFE);
      applyStimulus();

      // Four back-to-back accepts, then one output stall
      for (int k = 0; k < 4; k++) begin
         inValid = 1'b1; reg1 = 5'(k); reg2 = 5'(k + 1); instr = $urandom;
         checkOutput("b2b_in_ready", 32'(inReady), 32'h1);
         applyStimulus();
         checkOutput("b2b_out_valid", 32'(outValid), 32'h1);
      end
      inValid = 1'b1; reg1 = 5'd3; instr = 32'h17FF_FFFE; outReady = 1'b0;
      #1;
      checkOutput("stall_in_ready", 32'(inReady), 32'h0);
      applyStimulus();
      outReady = 1'b1;
      applyStimulus();
      setIdle();
      checkOutput("after_stall_pc", pcOffset, 32'hFFFF_FFFE);
      applyStimulus();

      // Top register: zero register or ordinary register
      wbEn = 1'b1; wbAddr = 5'd31; wbData = 32'h55;
      applyStimulus();
      setIdle();
      inValid = 1'b1; reg1 = 5'd31;
      applyStimulus();
      setIdle();
      checkOutput("x31_rd1", readData1, X31_EXPECT);
      applyStimulus();

      // Reset in the middle of a stall, with a write-back pending
      inValid = 1'b1; reg1 = 5'd3; outReady = 1'b0;
      applyStimulus();
      setIdle();
      outReady = 1'b0; wbEn = 1'b1; wbAddr = 5'd2; wbData = 32'hDEAD;
      #3;
      reset = 1'b1;
      #1;
      checkOutput("midreset_out_valid", 32'(outValid), 32'h0);
      checkOutput("midreset_in_ready",  32'(inReady),  32'h1);
      checkOutput("midreset_rd1",       readData1, 32'h0);
      modelReset();
      @(posedge clock);
      @(negedge clock);
      setIdle();
      reset = 1'b0;
      @(posedge clock);
      #1;
      inValid = 1'b1; reg1 = 5'd2; reg2 = 5'd3;
      applyStimulus();
      setIdle();
      checkOutput("no_wb_in_reset", readData1, 32'h0);
      applyStimulus();

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         inValid  = ($urandom_range(0, 3) != 0);
         instr    = $urandom;
         reg1     = pickReg();
         reg2     = pickReg();
         aluSrc   = ($urandom_range(0, 2) == 0);
         memRead  = ($urandom_range(0, 3) == 0);
         memWrite = ($urandom_range(0, 3) == 0);
         wbEn     = ($urandom_range(0, 1) == 1);
         wbAddr   = pickReg();
         wbData   = $urandom;
         outReady = ($urandom_range(0, 9) < 6);
         applyStimulus();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
